bids22_host_ctrl: RTL and testbench



---
 rtl/bids22_auc_if.sv | 25 ++
 rtl/bids22_host_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_bids22_host_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bids22_auc_if.sv
// Control/status bus between the host sequencer and the bids22 auction unit.
interface bids22_auc_if #(
  parameter int OP_W = 4
);
  logic [OP_W-1:0] C_op;
  logic [31:0]     C_data;
  logic            C_start;
  logic            ready;
  logic [1:0]      err;
  logic            roundOver;
  logic [31:0]     maxBid;
  logic            X_win;
  logic            Y_win;
  logic            Z_win;

  modport master (
    output C_op, C_data, C_start,
    input  ready, err, roundOver, maxBid, X_win, Y_win, Z_win
  );

  modport slave (
    input  C_op, C_data, C_start,
    output ready, err, roundOver, maxBid, X_win, Y_win, Z_win
  );
endinterface

// File: rtl/bids22_host_ctrl.sv
// Host-side sequencer: loads and locks the bids22 auction unit, runs one round,
// waits for roundOver (bounded by TIMEOUT) and returns the result over valid/ready.
module bids22_host_ctrl #(
  parameter int TIMEOUT = 1024,
  parameter int OP_W    = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic        [31:0] cfg_key,
  input  logic        [31:0] cfg_x_val,
  input  logic        [31:0] cfg_y_val,
  input  logic        [31:0] cfg_z_val,
  input  logic        [2:0]  cfg_mask,
  input  logic        [31:0] cfg_timer,
  input  logic        [31:0] cfg_cost,
  input  logic        [15:0] cfg_round_len,
  bids22_auc_if.master       auc,
  output logic               res_valid,
  input  logic               res_ready,
  output logic        [2:0]  res_status,
  output logic        [1:0]  res_winner,
  output logic        [31:0] res_maxbid,
  output logic        [1:0]  res_err
);

  localparam logic [OP_W-1:0] OP_NOOP    = OP_W'(0);
  localparam logic [OP_W-1:0] OP_UNLOCK  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_LOCK    = OP_W'(2);
  localparam logic [OP_W-1:0] OP_LOADX   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_LOADY   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_LOADZ   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SETMASK = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SETTMR  = OP_W'(7);
  localparam logic [OP_W-1:0] OP_BIDCHG  = OP_W'(8);

  localparam logic [31:0] WAIT_LAST = 32'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_CHECK, S_RUN, S_WAIT, S_DONE
  } state_t;

  state_t            state_q;
  logic              locked_q;
  logic [2:0]        step_q;
  logic [15:0]       run_cnt_q;
  logic [15:0]       run_last_q;
  logic [31:0]       wait_cnt_q;
  logic [31:0]       key_q, xval_q, yval_q, zval_q, timer_q, cost_q;
  logic [2:0]        mask_q;
  logic              cfg_ready_q;
  logic [OP_W-1:0]   c_op_q;
  logic [31:0]       c_data_q;
  logic              c_start_q;
  logic              res_valid_q;
  logic [2:0]        res_status_q;
  logic [1:0]        res_winner_q;
  logic [31:0]       res_maxbid_q;
  logic [1:0]        res_err_q;

  logic [OP_W-1:0]   step_op_d;
  logic [31:0]       step_data_d;
  logic [2:0]        win_status_d;
  logic [1:0]        win_winner_d;

  // Returns {status, winner}; multiple winners resolve by priority X > Y > Z.
  function automatic logic [4:0] decode_win(input logic x, input logic y, input logic z);
    logic [1:0] cnt;
    logic [1:0] who;
    logic [2:0] st;
    cnt = {1'b0, x} + {1'b0, y} + {1'b0, z};
    who = x ? 2'd1 : (y ? 2'd2 : (z ? 2'd3 : 2'd0));
    st  = (cnt == 2'd0) ? 3'd3 : ((cnt == 2'd1) ? 3'd0 : 3'd4);
    return {st, who};
  endfunction

  always_comb begin
    step_op_d   = OP_NOOP;
    step_data_d = '0;
    case (step_q)
      3'd0: begin step_op_d = OP_UNLOCK;  step_data_d = key_q;          end
      3'd1: begin step_op_d = OP_LOADX;   step_data_d = xval_q;         end
      3'd2: begin step_op_d = OP_LOADY;   step_data_d = yval_q;         end
      3'd3: begin step_op_d = OP_LOADZ;   step_data_d = zval_q;         end
      3'd4: begin step_op_d = OP_SETMASK; step_data_d = {29'b0, mask_q}; end
      3'd5: begin step_op_d = OP_SETTMR;  step_data_d = timer_q;        end
      3'd6: begin step_op_d = OP_BIDCHG;  step_data_d = cost_q;         end
      default: begin step_op_d = OP_LOCK; step_data_d = key_q;          end
    endcase
  end

  always_comb begin
    {win_status_d, win_winner_d} = decode_win(auc.X_win, auc.Y_win, auc.Z_win);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      locked_q     <= 1'b0;
      step_q       <= 3'd0;
      run_cnt_q    <= '0;
      wait_cnt_q   <= '0;
      cfg_ready_q  <= 1'b1;
      c_op_q       <= OP_NOOP;
      c_data_q     <= '0;
      c_start_q    <= 1'b0;
      res_valid_q  <= 1'b0;
      res_status_q <= '0;
      res_winner_q <= '0;
      res_maxbid_q <= '0;
      res_err_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cfg_valid && cfg_ready_q) begin
            key_q       <= cfg_key;
            xval_q      <= cfg_x_val;
            yval_q      <= cfg_y_val;
            zval_q      <= cfg_z_val;
            mask_q      <= cfg_mask;
            timer_q     <= cfg_timer;
            cost_q      <= cfg_cost;
            run_last_q  <= (cfg_round_len == 16'd0) ? 16'd0 : cfg_round_len - 16'd1;
            step_q      <= locked_q ? 3'd0 : 3'd1;
            cfg_ready_q <= 1'b0;
            state_q     <= S_ISSUE;
          end
        end
        // Opcode is only presented when the unit can take it; otherwise NoOp.
        S_ISSUE: begin
          if (auc.ready) begin
            c_op_q   <= step_op_d;
            c_data_q <= step_data_d;
            state_q  <= S_CHECK;
          end else begin
            c_op_q   <= OP_NOOP;
            c_data_q <= '0;
          end
        end
        S_CHECK: begin
          c_op_q   <= OP_NOOP;
          c_data_q <= '0;
          if (auc.err != 2'b00) begin
            res_err_q    <= auc.err;
            res_status_q <= 3'd1;
            res_winner_q <= 2'd0;
            res_maxbid_q <= '0;
            res_valid_q  <= 1'b1;
            state_q      <= S_DONE;
          end else if (step_q == 3'd7) begin
            locked_q  <= 1'b1;
            c_start_q <= 1'b1;
            run_cnt_q <= '0;
            state_q   <= S_RUN;
          end else begin
            if (step_q == 3'd0) locked_q <= 1'b0;
            step_q  <= step_q + 3'd1;
            state_q <= S_ISSUE;
          end
        end
        // roundOver is deliberately ignored while the round is held open.
        S_RUN: begin
          if (run_cnt_q == run_last_q) begin
            c_start_q  <= 1'b0;
            wait_cnt_q <= '0;
            state_q    <= S_WAIT;
          end else begin
            run_cnt_q <= run_cnt_q + 16'd1;
          end
        end
        S_WAIT: begin
          if (auc.roundOver) begin
            res_status_q <= win_status_d;
            res_winner_q <= win_winner_d;
            res_maxbid_q <= auc.maxBid;
            res_err_q    <= 2'd0;
            res_valid_q  <= 1'b1;
            state_q      <= S_DONE;
          end else if (wait_cnt_q == WAIT_LAST) begin
            res_status_q <= 3'd2;
            res_winner_q <= 2'd0;
            res_maxbid_q <= '0;
            res_err_q    <= 2'd0;
            res_valid_q  <= 1'b1;
            state_q      <= S_DONE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 32'd1;
          end
        end
        S_DONE: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            cfg_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cfg_ready   = cfg_ready_q;
  assign auc.C_op    = c_op_q;
  assign auc.C_data  = c_data_q;
  assign auc.C_start = c_start_q;
  assign res_valid   = res_valid_q;
  assign res_status  = res_status_q;
  assign res_winner  = res_winner_q;
  assign res_maxbid  = res_maxbid_q;
  assign res_err     = res_err_q;

endmodule

// File: tb/tb_bids22_host_ctrl.sv
// Randomized bench for bids22_host_ctrl; the bench plays the auction unit and
// predicts each round's opcode stream and result from the sequencing rules.
module tb_bids22_host_ctrl;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_key, cfg_x_val, cfg_y_val, cfg_z_val, cfg_timer, cfg_cost;
  logic [2:0]  cfg_mask;
  logic [15:0] cfg_round_len;
  logic        res_valid;
  logic        res_ready;
  logic [2:0]  res_status;
  logic [1:0]  res_winner;
  logic [31:0] res_maxbid;
  logic [1:0]  res_err;

  bids22_auc_if bus ();

  bids22_host_ctrl #(.TIMEOUT(TO), .OP_W(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_key(cfg_key), .cfg_x_val(cfg_x_val), .cfg_y_val(cfg_y_val),
    .cfg_z_val(cfg_z_val), .cfg_mask(cfg_mask), .cfg_timer(cfg_timer),
    .cfg_cost(cfg_cost), .cfg_round_len(cfg_round_len),
    .auc(bus),
    .res_valid(res_valid), .res_ready(res_ready), .res_status(res_status),
    .res_winner(res_winner), .res_maxbid(res_maxbid), .res_err(res_err)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  bit locked_m = 1'b0;

  task automatic run_round(
    input string name,
    input logic [31:0] key, input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
    input logic [2:0] mask, input logic [31:0] timer, input logic [31:0] cost,
    input logic [15:0] len, input int err_idx, input logic [1:0] err_val,
    input int stall_op, input int stall_len, input int ro_delay, input bit ro_run,
    input bit xw, input bit yw, input bit zw, input logic [31:0] mb, input bit rst_run);
    logic [3:0]  eop[$];
    logic [31:0] edat[$];
    int nlimit, nops, nstart, nwait, stall_left, cyc, nwin, explen;
    bit started, got_res;
    logic [2:0]  est;
    logic [1:0]  ewin, eerr;
    logic [31:0] emb;
    nops = 0; nstart = 0; nwait = 0; stall_left = 0; cyc = 0;
    started = 1'b0; got_res = 1'b0;
    if (locked_m) begin eop.push_back(4'd1); edat.push_back(key); end
    eop.push_back(4'd3); edat.push_back(x);
    eop.push_back(4'd4); edat.push_back(y);
    eop.push_back(4'd5); edat.push_back(z);
    eop.push_back(4'd6); edat.push_back({29'b0, mask});
    eop.push_back(4'd7); edat.push_back(timer);
    eop.push_back(4'd8); edat.push_back(cost);
    eop.push_back(4'd2); edat.push_back(key);
    nlimit = (err_idx >= 0) ? err_idx + 1 : eop.size();
    explen = (len == 16'd0) ? 1 : int'(len);
    bus.ready = 1'b1;

    @(negedge clk);
    tests_run++;
    if (cfg_ready !== 1'b1) begin
      tests_failed++; $display("FAIL %s cfg_ready_idle got %b want 1", name, cfg_ready);
    end
    cfg_valid = 1'b1; cfg_key = key; cfg_x_val = x; cfg_y_val = y; cfg_z_val = z;
    cfg_mask = mask; cfg_timer = timer; cfg_cost = cost; cfg_round_len = len;
    @(negedge clk);
    // Keep offering junk configurations while busy; they must be ignored.
    cfg_key = $urandom; cfg_x_val = $urandom; cfg_y_val = $urandom; cfg_z_val = $urandom;
    cfg_mask = 3'($urandom); cfg_timer = $urandom; cfg_cost = $urandom;
    cfg_round_len = 16'($urandom_range(0, 3));

    while (!got_res && cyc < 2000) begin
      bus.err = 2'b00; bus.roundOver = 1'b0;
      bus.X_win = 1'b0; bus.Y_win = 1'b0; bus.Z_win = 1'b0; bus.maxBid = $urandom;
      if (res_valid === 1'b1) begin
        got_res = 1'b1;
      end else begin
        if (stall_left > 0) begin
          tests_run++;
          if (bus.C_op !== 4'd0) begin
            tests_failed++; $display("FAIL %s stall_op got %0d want 0", name, bus.C_op);
          end
          stall_left--;
          if (stall_left == 0) bus.ready = 1'b1;
        end else if (bus.C_op !== 4'd0) begin
          tests_run++;
          if (nops >= nlimit) begin
            tests_failed++; $display("FAIL %s extra_op got %0d want none", name, bus.C_op);
          end else if (bus.C_op !== eop[nops] || bus.C_data !== edat[nops]) begin
            tests_failed++;
            $display("FAIL %s op%0d got %0d/%h want %0d/%h", name, nops, bus.C_op, bus.C_data,
                     eop[nops], edat[nops]);
          end
          if (nops == err_idx) bus.err = err_val;
          nops++;
          if (nops >= nlimit) cfg_valid = 1'b0;
          if (stall_op >= 0 && nops < eop.size() && stall_len > 0)
            if (int'(eop[nops]) == stall_op) begin bus.ready = 1'b0; stall_left = stall_len; end
        end
        if (bus.C_start === 1'b1) begin
          started = 1'b1;
          nstart++;
          tests_run++;
          if (bus.C_op !== 4'd0) begin
            tests_failed++; $display("FAIL %s op_in_run got %0d want 0", name, bus.C_op);
          end
          if (ro_run && nstart == 1) begin
            bus.roundOver = 1'b1; bus.X_win = 1'b1; bus.Y_win = 1'b1;
          end
          if (rst_run && nstart == 2) begin
            reset_n = 1'b0;
            @(negedge clk);
            tests_run++;
            if (bus.C_start !== 1'b0 || cfg_ready !== 1'b1 || res_valid !== 1'b0) begin
              tests_failed++;
              $display("FAIL %s reset_abort got start=%b rdy=%b vld=%b want 0/1/0", name,
                       bus.C_start, cfg_ready, res_valid);
            end
            reset_n = 1'b1; bus.roundOver = 1'b0; bus.X_win = 1'b0; bus.Y_win = 1'b0;
            locked_m = 1'b0;
            return;
          end
        end else if (started) begin
          if (ro_delay >= 0 && nwait == ro_delay) begin
            bus.roundOver = 1'b1; bus.X_win = xw; bus.Y_win = yw; bus.Z_win = zw; bus.maxBid = mb;
          end
          nwait++;
        end
        @(negedge clk);
        cyc++;
      end
    end

    cfg_valid = 1'b0;
    bus.ready = 1'b1;
    if (!got_res) begin
      tests_run++; tests_failed++;
      $display("FAIL %s no_result got none want res_valid within 2000 cycles", name);
      return;
    end

    if (err_idx >= 0) begin
      est = 3'd1; ewin = 2'd0; emb = 32'd0; eerr = err_val;
      tests_run++;
      if (nstart != 0) begin
        tests_failed++; $display("FAIL %s start_on_abort got %0d want 0", name, nstart);
      end
    end else begin
      eerr = 2'd0;
      tests_run++;
      if (nstart != explen) begin
        tests_failed++; $display("FAIL %s run_len got %0d want %0d", name, nstart, explen);
      end
      if (ro_delay < 0 || ro_delay >= TO) begin
        est = 3'd2; ewin = 2'd0; emb = 32'd0;
        tests_run++;
        if (nwait != TO) begin
          tests_failed++; $display("FAIL %s timeout_lat got %0d want %0d", name, nwait, TO);
        end
      end else begin
        nwin = int'(xw) + int'(yw) + int'(zw);
        emb = mb;
        est = (nwin == 0) ? 3'd3 : ((nwin == 1) ? 3'd0 : 3'd4);
        ewin = xw ? 2'd1 : (yw ? 2'd2 : (zw ? 2'd3 : 2'd0));
        tests_run++;
        if (nwait != ro_delay + 1) begin
          tests_failed++; $display("FAIL %s result_lat got %0d want %0d", name, nwait, ro_delay + 1);
        end
      end
    end
    tests_run++;
    if (nops != nlimit) begin
      tests_failed++; $display("FAIL %s op_count got %0d want %0d", name, nops, nlimit);
    end
    tests_run++;
    if (res_status !== est || res_winner !== ewin || res_maxbid !== emb || res_err !== eerr) begin
      tests_failed++;
      $display("FAIL %s result got st=%0d win=%0d mb=%0d err=%0d want st=%0d win=%0d mb=%0d err=%0d",
               name, res_status, res_winner, res_maxbid, res_err, est, ewin, emb, eerr);
    end
    repeat ($urandom_range(1, 4)) begin
      bus.maxBid = $urandom; bus.X_win = 1'($urandom); bus.roundOver = 1'($urandom);
      @(negedge clk);
      tests_run++;
      if (res_valid !== 1'b1 || res_status !== est || res_winner !== ewin ||
          res_maxbid !== emb || res_err !== eerr) begin
        tests_failed++;
        $display("FAIL %s hold got vld=%b st=%0d mb=%0d want vld=1 st=%0d mb=%0d", name,
                 res_valid, res_status, res_maxbid, est, emb);
      end
    end
    bus.roundOver = 1'b0; bus.X_win = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    tests_run++;
    if (res_valid !== 1'b0 || cfg_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s release got vld=%b rdy=%b want 0/1", name, res_valid, cfg_ready);
    end
    if (err_idx >= 0) begin
      if (locked_m && err_idx > 0) locked_m = 1'b0;
    end else begin
      locked_m = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus.C_op !== 4'd0 || bus.C_data !== 32'd0 || bus.C_start !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl got op=%0d data=%h start=%b want 0/0/0", bus.C_op, bus.C_data, bus.C_start);
    end
    tests_run++;
    if (cfg_ready !== 1'b1 || res_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_hs got rdy=%b vld=%b want 1/0", cfg_ready, res_valid);
    end
    tests_run++;
    if (res_status !== 3'd0 || res_winner !== 2'd0 || res_maxbid !== 32'd0 || res_err !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_res got st=%0d win=%0d mb=%0d err=%0d want 0", res_status, res_winner,
               res_maxbid, res_err);
    end
    locked_m = 1'b0;
  endtask

  task automatic test_basic();
    run_round("basic", 32'h0F0F0F0F, 32'd100, 32'd200, 32'd300, 3'd7, 32'd50, 32'd10, 16'd4,
              -1, 2'd0, -1, 0, 2, 1'b0, 1'b0, 1'b1, 1'b0, 32'd150, 1'b0);
  endtask

  task automatic test_relock();
    run_round("relock", $urandom, $urandom, $urandom, $urandom, 3'($urandom), $urandom, $urandom,
              16'd3, -1, 2'd0, -1, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, $urandom, 1'b0);
  endtask

  // Starts locked, so LoadY is the third issued op.
  task automatic test_error_abort();
    run_round("err_abort", 32'hA5A55A5A, $urandom, $urandom, $urandom, 3'd5, $urandom, $urandom,
              16'd2, 2, 2'b10, -1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic test_timeout();
    run_round("timeout", $urandom, $urandom, $urandom, $urandom, 3'd3, $urandom, $urandom,
              16'd0, -1, 2'd0, -1, 0, -1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic test_stall_multi();
    run_round("stall_multi", $urandom, $urandom, $urandom, $urandom, 3'd7, $urandom, $urandom,
              16'd3, -1, 2'd0, 7, 5, 1, 1'b1, 1'b1, 1'b0, 1'b1, 32'd777, 1'b0);
  endtask

  task automatic test_ro_at_timeout();
    run_round("ro_at_timeout", $urandom, $urandom, $urandom, $urandom, 3'd1, $urandom, $urandom,
              16'd1, -1, 2'd0, -1, 0, TO - 1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hCAFE0001, 1'b0);
  endtask

  task automatic test_no_winner();
    run_round("no_winner", $urandom, $urandom, $urandom, $urandom, 3'd0, $urandom, $urandom,
              16'd2, -1, 2'd0, -1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd5, 1'b0);
  endtask

  task automatic test_reset_in_run();
    run_round("reset_in_run", $urandom, $urandom, $urandom, $urandom, 3'd7, $urandom, $urandom,
              16'd5, -1, 2'd0, -1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    run_round("after_reset", 32'h11223344, $urandom, $urandom, $urandom, 3'd6, $urandom, $urandom,
              16'd2, -1, 2'd0, -1, 0, 3, 1'b0, 1'b0, 1'b0, 1'b1, 32'd99, 1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      int ei;
      ei = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : -1;
      run_round("random", $urandom, $urandom, $urandom, $urandom, 3'($urandom), $urandom, $urandom,
                16'($urandom_range(0, 6)), ei, 2'($urandom_range(1, 3)),
                int'($urandom_range(3, 8)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, TO + 3)), 1'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), $urandom, 1'b0);
    end
  endtask

  initial begin
    reset_n = 1'b0; cfg_valid = 1'b0; res_ready = 1'b0;
    cfg_key = '0; cfg_x_val = '0; cfg_y_val = '0; cfg_z_val = '0;
    cfg_mask = '0; cfg_timer = '0; cfg_cost = '0; cfg_round_len = '0;
    bus.ready = 1'b1; bus.err = 2'b00; bus.roundOver = 1'b0; bus.maxBid = '0;
    bus.X_win = 1'b0; bus.Y_win = 1'b0; bus.Z_win = 1'b0;
    test_reset();
    test_basic();
    test_relock();
    test_error_abort();
    test_timeout();
    test_stall_multi();
    test_ro_at_timeout();
    test_no_winner();
    test_reset_in_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
